uart_sram_loader: RTL and testbench

Byte-to-word loader sitting directly downstream of the UART receiver in the uart2sram path. It consumes each received byte and its one-cycle strobe and frame-error flag, packs four good bytes big-endian into a 32-bit MIPS word, and writes the word to external asynchronous SRAM with a timed write-enable pulse. Successive words go to incrementing addresses until a programmed word count is reached. Frame errors and overruns are reported as sticky flags.

---
 rtl/uart2sram_pkg.sv | 13 +
 rtl/sram_write_ctrl.sv | 87 ++++++++
 rtl/uart_sram_loader.sv | 131 +++++++++++++
 tb/tb_uart_sram_loader.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart2sram_pkg.sv
// Shared types for the uart2sram path: write-FSM states and packing geometry.
package uart2sram_pkg;

    typedef enum logic [1:0] {
        W_IDLE,
        W_SETUP,
        W_PULSE,
        W_HOLD
    } wstate_e;

    localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/sram_write_ctrl.sv
// Asynchronous-SRAM write sequencer: setup, timed WE pulse, hold, then address/count advance.
module sram_write_ctrl
    import uart2sram_pkg::*;
#(
    parameter int unsigned ADDR_W    = 20,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned WE_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              req_i,
    input  logic [31:0]       word_i,
    output logic              ready_o,
    output logic              wr_done_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [31:0]       sram_dout_o,
    output logic              sram_ce_n_o,
    output logic              sram_we_n_o,
    output logic [ADDR_W:0]   word_count_o
);

    localparam int unsigned CNT_W = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

    wstate_e           state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       dout_q;
    logic              ce_n_q;
    logic              we_n_q;
    logic [ADDR_W:0]   count_q;

    // The write buffer is occupied exactly while the FSM is away from W_IDLE.
    assign ready_o      = (state_q == W_IDLE);
    assign wr_done_o    = (state_q == W_HOLD);
    assign sram_addr_o  = addr_q;
    assign sram_dout_o  = dout_q;
    assign sram_ce_n_o  = ce_n_q;
    assign sram_we_n_o  = we_n_q;
    assign word_count_o = count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= W_IDLE;
            cnt_q   <= '0;
            addr_q  <= ADDR_W'(BASE_ADDR);
            dout_q  <= '0;
            ce_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            count_q <= '0;
        end else begin
            case (state_q)
                W_IDLE: begin
                    if (clear_i) begin
                        addr_q  <= ADDR_W'(BASE_ADDR);
                        count_q <= '0;
                    end else if (req_i) begin
                        dout_q  <= word_i;
                        ce_n_q  <= 1'b0;
                        state_q <= W_SETUP;
                    end
                end
                W_SETUP: begin
                    we_n_q  <= 1'b0;
                    cnt_q   <= CNT_W'(WE_CYCLES - 1);
                    state_q <= W_PULSE;
                end
                W_PULSE: begin
                    if (cnt_q == '0) begin
                        we_n_q  <= 1'b1;
                        state_q <= W_HOLD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                W_HOLD: begin
                    ce_n_q  <= 1'b1;
                    addr_q  <= addr_q + 1'b1;
                    count_q <= count_q + 1'b1;
                    state_q <= W_IDLE;
                end
                default: state_q <= W_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_sram_loader.sv
// Packs received UART bytes big-endian into 32-bit words and streams them to async SRAM.
module uart_sram_loader
    import uart2sram_pkg::*;
#(
    parameter int unsigned ADDR_W    = 20,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned WORDS     = 1024,
    parameter int unsigned WE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    input  logic              byte_frame_err,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_dout,
    output logic              sram_ce_n,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output logic              busy,
    output logic              done,
    output logic              frame_error,
    output logic              overrun,
    output logic [ADDR_W:0]   word_count
);

    localparam int unsigned      IDX_W      = $clog2(BYTES_PER_WORD);
    localparam int unsigned      SHIFT_W    = 8 * (BYTES_PER_WORD - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(BYTES_PER_WORD - 1);
    localparam logic [ADDR_W:0]  LAST_COUNT = (ADDR_W + 1)'(WORDS - 1);

    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               fe_q, fe_d;
    logic               ov_q, ov_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;

    logic        ready;
    logic        wr_done;
    logic        start_eff;
    logic        byte_ok;
    logic        byte_good;
    logic        word_last;
    logic        wr_req;
    logic [31:0] word_full;

    assign start_eff = start & ready;
    assign byte_ok   = byte_valid & busy_q & ~start_eff;
    assign byte_good = byte_ok & ~byte_frame_err;
    assign word_last = byte_good & (idx_q == LAST_IDX);
    assign wr_req    = word_last & ready;
    assign word_full = {shift_q, byte_in};

    always_comb begin
        busy_d  = busy_q;
        done_d  = done_q;
        fe_d    = fe_q;
        ov_d    = ov_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        if (start_eff) begin
            busy_d = 1'b1;
            done_d = 1'b0;
            fe_d   = 1'b0;
            ov_d   = 1'b0;
            idx_d  = '0;
        end else begin
            if (byte_ok && byte_frame_err) begin
                fe_d = 1'b1;
            end
            if (byte_good) begin
                shift_d = {shift_q[SHIFT_W-9:0], byte_in};
                idx_d   = idx_q + 1'b1;
            end
            if (word_last && !ready) begin
                ov_d = 1'b1;
            end
        end
        // wr_done only occurs while the FSM is busy, so it never collides with start_eff.
        if (wr_done && (word_count == LAST_COUNT)) begin
            done_d = 1'b1;
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            busy_q  <= busy_d;
            done_q  <= done_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    sram_write_ctrl #(
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(BASE_ADDR),
        .WE_CYCLES(WE_CYCLES)
    ) u_wr (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (start_eff),
        .req_i       (wr_req),
        .word_i      (word_full),
        .ready_o     (ready),
        .wr_done_o   (wr_done),
        .sram_addr_o (sram_addr),
        .sram_dout_o (sram_dout),
        .sram_ce_n_o (sram_ce_n),
        .sram_we_n_o (sram_we_n),
        .word_count_o(word_count)
    );

    assign sram_oe_n   = 1'b1;
    assign busy        = busy_q;
    assign done        = done_q;
    assign frame_error = fe_q;
    assign overrun     = ov_q;

endmodule

// File: tb/tb_uart_sram_loader.sv
// Scoreboard bench for uart_sram_loader: byte-stream reference model predicts SRAM writes and status.
module tb_uart_sram_loader;

    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned BASE_ADDR = 14;
    localparam int unsigned WORDS     = 3;
    localparam int unsigned WE_CYCLES = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_frame_err;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_dout;
    logic              sram_ce_n;
    logic              sram_we_n;
    logic              sram_oe_n;
    logic              busy;
    logic              done;
    logic              frame_error;
    logic              overrun;
    logic [ADDR_W:0]   word_count;

    uart_sram_loader #(
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(BASE_ADDR),
        .WORDS    (WORDS),
        .WE_CYCLES(WE_CYCLES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .byte_in       (byte_in),
        .byte_valid    (byte_valid),
        .byte_frame_err(byte_frame_err),
        .sram_addr     (sram_addr),
        .sram_dout     (sram_dout),
        .sram_ce_n     (sram_ce_n),
        .sram_we_n     (sram_we_n),
        .sram_oe_n     (sram_oe_n),
        .busy          (busy),
        .done          (done),
        .frame_error   (frame_error),
        .overrun       (overrun),
        .word_count    (word_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t exp_q[$];

    // Reference model state: edge-indexed occupancy instead of FSM states.
    bit         m_armed;
    int         m_done_at;
    bit         m_fe;
    bit         m_ov;
    int         m_accepted;
    int         m_busy_until;
    int         m_addr;
    logic [7:0] m_bytes[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_armed      = 0;
        m_done_at    = -1;
        m_fe         = 0;
        m_ov         = 0;
        m_accepted   = 0;
        m_busy_until = 0;
        m_addr       = BASE_ADDR;
        m_bytes.delete();
    endtask

    // e is the index of the clock edge that will sample these inputs.
    task automatic model_step(input int e, input logic v, input logic [7:0] b,
                              input logic fe, input logic st, input logic r);
        bit idle;
        bit done_now;
        wr_t w;
        idle     = (e > m_busy_until);
        done_now = (m_done_at >= 0) && (e > m_done_at);
        if (r) begin
            model_reset();
            return;
        end
        if (st && idle) begin
            m_armed    = 1;
            m_done_at  = -1;
            m_fe       = 0;
            m_ov       = 0;
            m_accepted = 0;
            m_addr     = BASE_ADDR;
            m_bytes.delete();
            return;
        end
        if (v && m_armed && !done_now) begin
            if (fe) begin
                m_fe = 1;
            end else begin
                m_bytes.push_back(b);
                if (m_bytes.size() == 4) begin
                    if (idle) begin
                        w.addr = ADDR_W'(m_addr);
                        w.data = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                        exp_q.push_back(w);
                        m_busy_until = e + WE_CYCLES + 2;
                        m_addr       = (m_addr + 1) % (1 << ADDR_W);
                        m_accepted++;
                        if (m_accepted == WORDS) m_done_at = m_busy_until;
                    end else begin
                        m_ov = 1;
                    end
                    m_bytes.delete();
                end
            end
        end
    endtask

    task automatic cycle(input logic v, input logic [7:0] b, input logic fe,
                         input logic st, input logic r);
        @(posedge clk);
        #1;
        byte_valid     = v;
        byte_in        = b;
        byte_frame_err = fe;
        start          = st;
        rst            = r;
        model_step(edge_n + 1, v, b, fe, st, r);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send(input logic [7:0] b, input logic fe, input int gap);
        cycle(1'b1, b, fe, 1'b0, 1'b0);
        idle(gap);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 3; i >= 0; i--) send(w[i*8 +: 8], 1'b0, gap);
    endtask

    task automatic pulse_start();
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        idle(1);
    endtask

    task automatic wait_we_low();
        n_checks++;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            if (sram_we_n === 1'b0) return;
        end
        n_fail++;
        $display("FAIL we_wait: sram_we_n stayed high, required low within 40 cycles");
    endtask

    task automatic check_status(input string tag);
        bit exp_done;
        @(negedge clk);
        exp_done = (m_done_at >= 0) && (edge_n > m_done_at);
        check({tag, ".busy"},        32'(busy),        32'(m_armed && !exp_done));
        check({tag, ".done"},        32'(done),        32'(exp_done));
        check({tag, ".frame_error"}, 32'(frame_error), 32'(m_fe));
        check({tag, ".overrun"},     32'(overrun),     32'(m_ov));
        check({tag, ".word_count"},  32'(word_count),  32'(m_accepted));
        check({tag, ".sram_addr"},   32'(sram_addr),   32'(m_addr));
        check({tag, ".ce_n"},        32'(sram_ce_n),   32'd1);
        check({tag, ".we_n"},        32'(sram_we_n),   32'd1);
        check({tag, ".oe_n"},        32'(sram_oe_n),   32'd1);
    endtask

    // Monitor: every WE falling edge must match the next predicted write.
    logic prev_we    = 1'b1;
    bit   in_pulse   = 0;
    bit   pulse_abort = 0;
    int   width      = 0;
    wr_t  cur;

    always @(negedge clk) begin
        if (in_pulse && rst === 1'b1) pulse_abort = 1;
        if (prev_we === 1'b1 && sram_we_n === 1'b0) begin
            in_pulse = 1;
            width    = 1;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write predicted",
                         sram_addr, sram_dout);
            end else begin
                cur = exp_q.pop_front();
                check("wr_addr", 32'(sram_addr), 32'(cur.addr));
                check("wr_data", sram_dout, cur.data);
                check("wr_ce_n", 32'(sram_ce_n), 32'd0);
            end
        end else if (in_pulse && sram_we_n === 1'b0) begin
            width++;
        end else if (in_pulse && sram_we_n === 1'b1) begin
            if (!pulse_abort) begin
                check("we_width", 32'(width), 32'(WE_CYCLES));
                check("hold_ce_n", 32'(sram_ce_n), 32'd0);
            end
            in_pulse    = 0;
            pulse_abort = 0;
        end
        prev_we = sram_we_n;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        rst = 1'b1; start = 1'b0; byte_in = 8'h00; byte_valid = 1'b0; byte_frame_err = 1'b0;
        repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        idle(1);
        check_status("reset");
        check("reset.dout", sram_dout, 32'h0);

        // Bytes before start are ignored.
        send_word(32'h01020304, 1);
        idle(10);
        check_status("disarmed");

        pulse_start();
        send_word(32'h12345678, 2);
        idle(12);
        check_status("word1");
        send_word(32'hDEADBEEF, 3);
        send(8'hAA, 1'b0, 1);
        send(8'hBB, 1'b1, 1);
        send(8'hCC, 1'b0, 1);
        send(8'hDD, 1'b0, 1);
        send(8'hEE, 1'b0, 1);
        idle(12);
        check_status("done");
        send_word(32'hCAFEF00D, 1);
        idle(12);
        check_status("after_done");

        pulse_start();
        check_status("restart");

        // Back-to-back bytes: the 8th lands on the hold-exit edge and overruns.
        for (int i = 0; i < 12; i++) send(8'(8'h30 + i), 1'b0, 0);
        idle(12);
        check_status("overrun");
        send_word(32'h0BADF00D, 0);
        idle(12);
        check_status("overrun_done");

        pulse_start();
        send_word(32'h11223344, 1);
        wait_we_low();
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        idle(12);
        check_status("start_ignored");

        send_word(32'h55667788, 1);
        wait_we_low();
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        idle(1);
        check_status("rst_mid");
        check("rst_mid.dout", sram_dout, 32'h0);

        for (int r = 0; r < 5; r++) begin
            pulse_start();
            for (int i = 0; i < 14; i++)
                send(8'($urandom), ($urandom_range(0, 7) == 0), $urandom_range(0, 4));
            idle(12);
            check_status("random");
        end

        idle(5);
        check("exp_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
